// File: rtl/jtag_sram_hold_responder.sv
// SRAM-side responder for the JTAG HOLD/HLDA handshake: stalls the CPU at a bus-cycle boundary,
// hands the SRAM bus to JTAG and times writes. Optional feature macro: JTAG_FORCE_GRANT_EN.
module jtag_sram_hold_responder #(
  parameter int unsigned WR_CYCLES    = 2,
  parameter int unsigned SYNC_TIMEOUT = 255
) (
  input  logic        clk24,
  input  logic        reset_n,
  input  logic        iHOLD,
  output logic        oHLDA,
  input  logic        iCPU_SYNC,
  output logic        oCPU_READY,
  input  logic [17:0] iCPU_ADDR,
  input  logic [15:0] iCPU_DATA,
  input  logic        iCPU_WE_N,
  input  logic [17:0] iJTAG_ADDR,
  input  logic [15:0] iJTAG_DATA,
  input  logic        iJTAG_WR_N,
  input  logic        iJTAG_SELECT,
  output logic [15:0] oJTAG_DATA_TO_HOST,
  output logic [17:0] oSRAM_ADDR,
  output logic [15:0] oSRAM_DQ_OUT,
  output logic        oSRAM_DQ_OE,
  output logic        oSRAM_WE_N,
  input  logic [15:0] iSRAM_DQ_IN
);

  typedef enum logic [2:0] {
    StIdle, StWaitSync, StGranted, StWrSetup, StWrPulse, StWrHold, StRelease
  } stateT;

  localparam logic [3:0] PulseLast = 4'(WR_CYCLES - 1);

  stateT       stateQ, stateD;
  logic        holdQ;
  logic        wrReq, wrReqQ, wrFallQ;
  logic [3:0]  pulseCntQ, pulseCntD;
  logic        latchEn;
  logic [17:0] latchAddrQ;
  logic [15:0] latchDataQ;
  logic [15:0] hostDataQ;
  logic        forceGrant;

  // A deselected decoder never requests a write, whatever WR_N does.
  assign wrReq = iJTAG_WR_N | ~iJTAG_SELECT;

  always_ff @(posedge clk24) begin
    if (!reset_n) begin
      stateQ     <= StIdle;
      holdQ      <= 1'b0;
      wrReqQ     <= 1'b1;
      wrFallQ    <= 1'b0;
      pulseCntQ  <= '0;
      latchAddrQ <= '0;
      latchDataQ <= '0;
      hostDataQ  <= '0;
    end else begin
      stateQ    <= stateD;
      holdQ     <= iHOLD;
      wrReqQ    <= wrReq;
      wrFallQ   <= wrReqQ & ~wrReq;
      pulseCntQ <= pulseCntD;
      if (stateQ == StGranted) hostDataQ <= iSRAM_DQ_IN;
      if (latchEn) begin
        latchAddrQ <= iJTAG_ADDR;
        latchDataQ <= iJTAG_DATA;
      end
    end
  end

`ifdef JTAG_FORCE_GRANT_EN
  localparam logic [7:0] TimeoutLast = 8'(SYNC_TIMEOUT - 1);
  logic [7:0] syncCntQ;

  always_ff @(posedge clk24) begin
    if (!reset_n || stateQ != StWaitSync) syncCntQ <= '0;
    else if (syncCntQ != TimeoutLast)     syncCntQ <= syncCntQ + 8'd1;
  end

  // Covers a halted CPU that never reaches a bus-cycle boundary.
  assign forceGrant = (stateQ == StWaitSync) && (syncCntQ == TimeoutLast);
`else
  logic unusedSyncTimeout;
  assign unusedSyncTimeout = ^SYNC_TIMEOUT;
  assign forceGrant        = 1'b0;
`endif

  always_comb begin
    stateD    = stateQ;
    pulseCntD = pulseCntQ;
    latchEn   = 1'b0;
    unique case (stateQ)
      StIdle:     if (holdQ) stateD = StWaitSync;
      StWaitSync: begin
        if (!holdQ)                       stateD = StIdle;
        else if (iCPU_SYNC || forceGrant) stateD = StGranted;
      end
      // A pending write wins over a HOLD drop; release follows once the write is done.
      StGranted: begin
        if (wrFallQ) begin
          stateD  = StWrSetup;
          latchEn = 1'b1;
        end else if (!holdQ) begin
          stateD = StRelease;
        end
      end
      StWrSetup: begin
        stateD    = StWrPulse;
        pulseCntD = '0;
      end
      StWrPulse: begin
        if (pulseCntQ == PulseLast) stateD = StWrHold;
        else                        pulseCntD = pulseCntQ + 4'd1;
      end
      StWrHold:  stateD = StGranted;
      StRelease: stateD = StIdle;
      default:   stateD = StIdle;
    endcase
  end

  always_comb begin
    oSRAM_ADDR   = iCPU_ADDR;
    oSRAM_DQ_OUT = iCPU_DATA;
    oSRAM_WE_N   = iCPU_WE_N;
    oSRAM_DQ_OE  = ~iCPU_WE_N;
    oHLDA        = 1'b0;
    oCPU_READY   = 1'b1;
    unique case (stateQ)
      StIdle, StWaitSync: begin
      end
      StGranted: begin
        oHLDA        = 1'b1;
        oCPU_READY   = 1'b0;
        oSRAM_ADDR   = iJTAG_ADDR;
        oSRAM_DQ_OUT = iJTAG_DATA;
        oSRAM_WE_N   = 1'b1;
        oSRAM_DQ_OE  = 1'b0;
      end
      StWrSetup, StWrPulse, StWrHold: begin
        oHLDA        = 1'b1;
        oCPU_READY   = 1'b0;
        oSRAM_ADDR   = latchAddrQ;
        oSRAM_DQ_OUT = latchDataQ;
        oSRAM_WE_N   = (stateQ != StWrPulse);
        oSRAM_DQ_OE  = 1'b1;
      end
      StRelease: oCPU_READY = 1'b0;
      default: begin
      end
    endcase
    // Reset takes the bus back to a safe, non-writing CPU view immediately.
    if (!reset_n) begin
      oSRAM_ADDR   = iCPU_ADDR;
      oSRAM_DQ_OUT = iCPU_DATA;
      oSRAM_WE_N   = 1'b1;
      oSRAM_DQ_OE  = 1'b0;
      oHLDA        = 1'b0;
      oCPU_READY   = 1'b1;
    end
  end

  assign oJTAG_DATA_TO_HOST = hostDataQ;

endmodule
